// File: rtl/sdm_decim.sv
// Third-order CIC decimator: 1-bit sigma-delta stream in, signed BITS-wide samples out every 2^LOG2R
// cycles. Define SDM_DECIM_SETTLE_EN to hold off dout_valid until the filter has filled.
module sdm_decim #(
  parameter int BITS  = 16,
  parameter int LOG2R = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            din,
  output logic [BITS-1:0] dout,
  output logic            dout_valid
);

  localparam int W  = 3 * LOG2R + 2;
  localparam int SH = 3 * LOG2R - (BITS - 1);
  localparam logic signed [W-1:0] MaxVal = W'((1 << (BITS - 1)) - 1);
  localparam logic signed [W-1:0] MinVal = ~MaxVal;

  logic [LOG2R-1:0] ph_q;
  logic [W-1:0]     i1_q, i2_q, i3_q;
  logic [W-1:0]     s_z_q, c1_z_q, c2_z_q;
  logic [BITS-1:0]  dout_q;
  logic             valid_q;

  logic                x_unused;
  logic [W-1:0]        x, c1, c2, c3;
  logic signed [W-1:0] c3_sh;
  logic [BITS-1:0]     sat_val;
  logic                tick;
  logic                settled;

  assign x_unused = 1'b0;

  always_comb begin
    x       = din ? W'(1) : {W{1'b1}};
    tick    = (ph_q == {LOG2R{1'b1}});
    c1      = i3_q - s_z_q;
    c2      = c1 - c1_z_q;
    c3      = c2 - c2_z_q;
    c3_sh   = $signed(c3) >>> SH;
    // Only full-scale positive input can exceed the range; clamp symmetrically anyway.
    if (c3_sh > MaxVal) begin
      sat_val = MaxVal[BITS-1:0];
    end else if (c3_sh < MinVal) begin
      sat_val = MinVal[BITS-1:0];
    end else begin
      sat_val = c3_sh[BITS-1:0];
    end
  end

`ifdef SDM_DECIM_SETTLE_EN
  logic [1:0] fill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= 2'd0;
    end else if (tick && (fill_q != 2'd3)) begin
      fill_q <= fill_q + 2'd1;
    end
  end

  always_comb begin
    settled = (fill_q == 2'd3);
  end
`else
  always_comb begin
    settled = 1'b1;
  end
`endif

  // Integrators wrap freely; the comb differences recover the exact result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q   <= '0;
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      s_z_q  <= '0;
      c1_z_q <= '0;
      c2_z_q <= '0;
    end else begin
      ph_q <= ph_q + LOG2R'(1);
      i1_q <= i1_q + x;
      i2_q <= i2_q + i1_q;
      i3_q <= i3_q + i2_q;
      if (tick) begin
        s_z_q  <= i3_q;
        c1_z_q <= c1;
        c2_z_q <= c2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= tick && settled;
      if (tick && settled) begin
        dout_q <= sat_val;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;

endmodule
